// File: rtl/att_session_ctrl_if.sv
// Core-side signals observed by the attestation session controller, plus its status outputs.
interface att_session_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic [15:0]      pc;
  logic             irq;
  logic             dma_en;
  logic [15:0]      dma_addr;
  logic             viol_reset;
  logic             att_active;
  logic             att_done;
  logic [CNT_W-1:0] session_cnt;

  modport master (
    output pc, irq, dma_en, dma_addr,
    input  viol_reset, att_active, att_done, session_cnt
  );

  modport slave (
    input  pc, irq, dma_en, dma_addr,
    output viol_reset, att_active, att_done, session_cnt
  );
endinterface

// File: rtl/att_session_ctrl.sv
// Sequences one attestation session through secure ROM: entry/exit points, atomicity,
// cycle budget; any breach holds viol_reset until the core reaches its reset handler.
module att_session_ctrl #(
  parameter logic [15:0] SMEM_BASE     = 16'hA000,
  parameter logic [15:0] SMEM_SIZE     = 16'h4000,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
  parameter logic [23:0] MAX_CYCLES    = 24'hFFFFFF,
  parameter int          CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  att_session_ctrl_if.slave    bus
);

  localparam logic [15:0] ENTRY_PC  = SMEM_BASE;
  localparam logic [15:0] EXIT_PC   = SMEM_BASE + SMEM_SIZE - 16'd2;
  localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd1;
  localparam logic [23:0] CYC_LAST  = MAX_CYCLES - 24'd1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    KILL
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      prev_pc_reg;
  logic [23:0]      cyc_reg, cyc_next;
  logic             done_next;
  logic             viol_reg, active_reg, done_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic in_smem, dma_smem, at_entry, intrusion;

  assign in_smem   = (bus.pc >= SMEM_BASE) && (bus.pc <= EXIT_PC);
  assign dma_smem  = bus.dma_en && (bus.dma_addr >= SMEM_BASE) && (bus.dma_addr <= SMEM_LAST);
  assign at_entry  = (bus.pc == ENTRY_PC);
  assign intrusion = bus.irq || bus.dma_en;

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dma_smem || (in_smem && !at_entry)) begin
          state_next = KILL;
        end else if (at_entry) begin
          cyc_next   = '0;
          state_next = intrusion ? KILL : ACTIVE;
        end
      end
      ACTIVE: begin
        // Violations are evaluated before the clean-exit test so they always win.
        if (intrusion) begin
          state_next = KILL;
        end else if (cyc_reg == CYC_LAST) begin
          state_next = KILL;
        end else if (!in_smem && (prev_pc_reg == EXIT_PC)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (!in_smem) begin
          state_next = KILL;
        end else begin
          cyc_next = cyc_reg + 24'd1;
        end
      end
      KILL: begin
        if ((bus.pc == RESET_HANDLER) && !intrusion) begin
          state_next = IDLE;
        end
      end
      default: state_next = KILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      prev_pc_reg <= '0;
      cyc_reg     <= '0;
      viol_reg    <= 1'b0;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      prev_pc_reg <= bus.pc;
      cyc_reg     <= cyc_next;
      viol_reg    <= (state_next == KILL);
      active_reg  <= (state_next == ACTIVE);
      done_reg    <= done_next;
      if (done_next) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.viol_reset  = viol_reg;
  assign bus.att_active  = active_reg;
  assign bus.att_done    = done_reg;
  assign bus.session_cnt = cnt_reg;

endmodule
